stbus_slot_sched: RTL and testbench



---
 rtl/stbus_slot_sched.sv | 191 +++++++++++++++++++
 tb/tb_stbus_slot_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stbus_slot_sched.sv
`timescale 1ns/1ps
// ST-BUS frame locker and 32-slot requester scheduler.
// Tracks frame/slot/bit position from f0 and issues per-requester tx/rx bit strobes.
module stbus_slot_sched #(
  parameter int NREQ     = 4,
  parameter int GOOD_MIN = 2,
  parameter int MISS_MAX = 3
) (
  input  logic            c4,
  input  logic            rst,
  input  logic            f0,
  input  logic            cfg_we,
  input  logic [4:0]      cfg_slot,
  input  logic            cfg_valid,
  input  logic [1:0]      cfg_owner,
  output logic [4:0]      slot,
  output logic [2:0]      bitn,
  output logic            sof,
  output logic            locked,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] tx_en,
  output logic [NREQ-1:0] rx_en
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  // Owners at or above NREQ never match a requester bit, so they read as idle.
  function automatic logic [NREQ-1:0] owner_onehot(input logic valid, input logic [1:0] owner);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      oh[i] = valid & (owner == 2'(i));
    end
    return oh;
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic [8:0]      cnt_r;
  logic [8:0]      cnt_s;
  logic [7:0]      good_r;
  logic [7:0]      good_s;
  logic [7:0]      miss_r;
  logic [7:0]      miss_s;
  logic [2:0]      map_r [0:31];
  logic            own_valid_r;
  logic            own_valid_s;
  logic [1:0]      own_r;
  logic [1:0]      own_s;
  logic [2:0]      entry_s;
  logic [NREQ-1:0] grant_s;
  logic            f0_low_s;
  logic            frame_end_s;
  logic            expected_s;
  logic            slot_start_s;

  // Frame FSM next-state: hunt for f0, confirm alignment, then flywheel.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r + 9'd1;
    good_s      = good_r;
    miss_s      = miss_r;
    f0_low_s    = ~f0;
    frame_end_s = (cnt_r == 9'd511);
    expected_s  = f0_low_s & frame_end_s;
    case (state_r)
      HUNT: begin
        if (f0_low_s) begin
          cnt_s   = 9'd0;
          good_s  = 8'd0;
          state_s = CHECK;
        end else begin
          state_s = HUNT;
        end
      end
      CHECK: begin
        if (expected_s) begin
          good_s = good_r + 8'd1;
          if (good_s == 8'(GOOD_MIN)) begin
            state_s = LOCK;
            miss_s  = 8'd0;
          end else begin
            state_s = CHECK;
          end
        end else if (f0_low_s) begin
          cnt_s  = 9'd0;
          good_s = 8'd0;
        end else if (frame_end_s) begin
          state_s = HUNT;
        end else begin
          state_s = CHECK;
        end
      end
      LOCK: begin
        // A one-cycle-early pulse is an error here and the missing pulse after it is another.
        if (expected_s) begin
          miss_s = 8'd0;
        end else if (f0_low_s | frame_end_s) begin
          miss_s = miss_r + 8'd1;
          if (miss_s == 8'(MISS_MAX)) begin
            state_s = HUNT;
          end else begin
            state_s = LOCK;
          end
        end else begin
          miss_s = miss_r;
        end
      end
      default: begin
        state_s = HUNT;
      end
    endcase
  end

  // Slot owner latch and lock-gated grant for the cycle being decoded.
  always_comb begin
    slot_start_s = (cnt_r[3:0] == 4'd0);
    entry_s      = map_r[cnt_r[8:4]];
    own_valid_s  = own_valid_r;
    own_s        = own_r;
    grant_s      = '0;
    if (slot_start_s) begin
      own_valid_s = entry_s[2];
      own_s       = entry_s[1:0];
    end else begin
      own_valid_s = own_valid_r;
      own_s       = own_r;
    end
    if (state_r == LOCK) begin
      grant_s = owner_onehot(own_valid_s, own_s);
    end else begin
      grant_s = '0;
    end
  end

  // Frame FSM, position counter and owner latch registers.
  always_ff @(posedge c4 or posedge rst) begin
    if (rst) begin
      state_r     <= HUNT;
      cnt_r       <= 9'd0;
      good_r      <= 8'd0;
      miss_r      <= 8'd0;
      own_valid_r <= 1'b0;
      own_r       <= 2'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      good_r      <= good_s;
      miss_r      <= miss_s;
      own_valid_r <= own_valid_s;
      own_r       <= own_s;
    end
  end

  // Slot map storage; a write on a slot-start edge is seen from the next occurrence.
  always_ff @(posedge c4 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        map_r[i] <= 3'd0;
      end
    end else if (cfg_we) begin
      map_r[cfg_slot] <= {cfg_valid, cfg_owner};
    end
  end

  // Registered outputs, one cycle behind the position counter.
  always_ff @(posedge c4 or posedge rst) begin
    if (rst) begin
      slot   <= 5'd0;
      bitn   <= 3'd0;
      sof    <= 1'b0;
      locked <= 1'b0;
      grant  <= '0;
      tx_en  <= '0;
      rx_en  <= '0;
    end else begin
      slot   <= cnt_r[8:4];
      bitn   <= cnt_r[3:1];
      sof    <= (cnt_r == 9'd0);
      locked <= (state_r == LOCK);
      grant  <= grant_s;
      tx_en  <= cnt_r[0] ? '0 : grant_s;
      rx_en  <= cnt_r[0] ? grant_s : '0;
    end
  end

endmodule

// File: tb/tb_stbus_slot_sched.sv
`timescale 1ns/1ps
// Bench for stbus_slot_sched: frame-level behavioural model checked every cycle,
// plus hand-derived expectations for lock latency, strobe counts and reset.
module tb_stbus_slot_sched;

  localparam int NREQ     = 3;
  localparam int GOOD_MIN = 2;
  localparam int MISS_MAX = 3;

  logic            c4 = 1'b0;
  logic            rst;
  logic            f0;
  logic            cfg_we;
  logic [4:0]      cfg_slot;
  logic            cfg_valid;
  logic [1:0]      cfg_owner;
  logic [4:0]      slot;
  logic [2:0]      bitn;
  logic            sof;
  logic            locked;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] tx_en;
  logic [NREQ-1:0] rx_en;

  stbus_slot_sched #(.NREQ(NREQ), .GOOD_MIN(GOOD_MIN), .MISS_MAX(MISS_MAX)) dut (
    .c4(c4), .rst(rst), .f0(f0), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
    .cfg_valid(cfg_valid), .cfg_owner(cfg_owner), .slot(slot), .bitn(bitn),
    .sof(sof), .locked(locked), .grant(grant), .tx_en(tx_en), .rx_en(rx_en)
  );

  always #122 c4 = ~c4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: frame position, lock mode (0 hunt, 1 check, 2 lock), counters, map.
  int m_pos, m_mode, m_good, m_miss, m_own;
  int m_map_v [32];
  int m_map_o [32];
  logic [4:0]      e_slot;
  logic [2:0]      e_bitn;
  logic            e_sof, e_locked;
  logic [NREQ-1:0] e_grant, e_tx, e_rx;

  int   tx_cnt [NREQ];
  int   rx_cnt [NREQ];
  int   gnt_cyc;
  int   lock_rise = -1;
  int   lock_fall = -1;
  logic prev_locked = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_mode = 0; m_good = 0; m_miss = 0; m_own = -1;
    for (int i = 0; i < 32; i++) begin
      m_map_v[i] = 0;
      m_map_o[i] = 0;
    end
    e_slot = '0; e_bitn = '0; e_sof = 1'b0; e_locked = 1'b0;
    e_grant = '0; e_tx = '0; e_rx = '0;
  endtask

  // Outputs shown after an edge describe the frame position held before it.
  task automatic model_step();
    int  own;
    int  old;
    bit  low;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_pos % 16 == 0) begin
      own = (m_map_v[m_pos / 16] != 0 && m_map_o[m_pos / 16] < NREQ) ? m_map_o[m_pos / 16] : -1;
    end else begin
      own = m_own;
    end
    m_own    = own;
    e_slot   = 5'(m_pos / 16);
    e_bitn   = 3'((m_pos % 16) / 2);
    e_sof    = (m_pos == 0);
    e_locked = (m_mode == 2);
    e_grant  = '0;
    if (m_mode == 2 && own >= 0) e_grant[own] = 1'b1;
    e_tx = (m_pos % 2 == 0) ? e_grant : '0;
    e_rx = (m_pos % 2 == 1) ? e_grant : '0;
    low   = !f0;
    old   = m_pos;
    m_pos = (m_pos + 1) % 512;
    case (m_mode)
      0: if (low) begin m_pos = 0; m_good = 0; m_mode = 1; end
      1: begin
        if (low && old == 511) begin
          m_good++;
          if (m_good >= GOOD_MIN) begin m_mode = 2; m_miss = 0; end
        end else if (low) begin
          m_pos = 0; m_good = 0;
        end else if (old == 511) begin
          m_mode = 0;
        end
      end
      2: begin
        if (low && old == 511) m_miss = 0;
        else if (low || old == 511) begin
          m_miss++;
          if (m_miss >= MISS_MAX) m_mode = 0;
        end
      end
      default: m_mode = 0;
    endcase
    if (cfg_we) begin
      m_map_v[cfg_slot] = int'(cfg_valid);
      m_map_o[cfg_slot] = int'(cfg_owner);
    end
  endtask

  // Compare process: every cycle, full output vector against the model.
  always @(negedge c4) begin
    check("outputs", 32'({slot, bitn, sof, locked, grant, tx_en, rx_en}),
          32'({e_slot, e_bitn, e_sof, e_locked, e_grant, e_tx, e_rx}));
    for (int i = 0; i < NREQ; i++) begin
      tx_cnt[i] += int'(tx_en[i]);
      rx_cnt[i] += int'(rx_en[i]);
    end
    if (grant != '0) gnt_cyc++;
    if (locked && !prev_locked) lock_rise = cyc;
    if (!locked && prev_locked) lock_fall = cyc;
    prev_locked = locked;
  end

  task automatic tick();
    @(posedge c4);
    cyc++;
    model_step();
    @(negedge c4);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NREQ; i++) begin
      tx_cnt[i] = 0;
      rx_cnt[i] = 0;
    end
    gnt_cyc = 0;
  endtask

  task automatic write_map(input int s, input bit v, input int o);
    cfg_we = 1'b1; cfg_slot = 5'(s); cfg_valid = v; cfg_owner = 2'(o);
    tick();
    cfg_we = 1'b0;
  endtask

  // One 512-cycle frame aligned to cnt=0; optional f0 at cnt=511 and map write at cnt=wr_at.
  task automatic frame(input bit pulse, input int wr_at, input int ws, input bit wv, input int wo);
    for (int i = 0; i < 512; i++) begin
      f0 = (pulse && i == 511) ? 1'b0 : 1'b1;
      if (i == wr_at) begin
        cfg_we = 1'b1; cfg_slot = 5'(ws); cfg_valid = wv; cfg_owner = 2'(wo);
      end else begin
        cfg_we = 1'b0;
      end
      tick();
    end
    f0 = 1'b1; cfg_we = 1'b0;
  endtask

  task automatic pulse_now();
    f0 = 1'b0;
    tick();
    f0 = 1'b1;
  endtask

  int t_ref;

  initial begin
    rst = 1'b1; f0 = 1'b1; cfg_we = 1'b0; cfg_slot = '0; cfg_valid = 1'b0; cfg_owner = '0;
    model_reset();
    clear_counts();
    repeat (3) tick();
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_locked_sof", 32'({locked, sof}), 32'd0);
    check("rst_grant", 32'({grant, tx_en, rx_en}), 32'd0);
    rst = 1'b0;

    write_map(3, 1'b1, 1);
    write_map(0, 1'b1, 0);
    write_map(5, 1'b1, 0);
    write_map(7, 1'b1, 3);
    write_map(10, 1'b1, 2);
    repeat (37) tick();

    // Lock acquisition
    pulse_now();
    t_ref = cyc;
    frame(1'b1, -1, 0, 1'b0, 0);
    frame(1'b1, -1, 0, 1'b0, 0);
    clear_counts();
    frame(1'b1, -1, 0, 1'b0, 0);
    check("lock_latency", 32'(lock_rise - t_ref), 32'd1025);
    check("tx1_per_frame", 32'(tx_cnt[1]), 32'd8);
    check("rx1_per_frame", 32'(rx_cnt[1]), 32'd8);
    check("tx0_per_frame", 32'(tx_cnt[0]), 32'd16);
    check("tx2_per_frame", 32'(tx_cnt[2]), 32'd8);
    check("grant_cycles_owner3_idle", 32'(gnt_cyc), 32'd64);

    // Flywheel: isolated misses are cleared by the next good pulse
    frame(1'b0, -1, 0, 1'b0, 0);
    frame(1'b1, -1, 0, 1'b0, 0);
    frame(1'b0, -1, 0, 1'b0, 0);
    frame(1'b0, -1, 0, 1'b0, 0);
    frame(1'b1, -1, 0, 1'b0, 0);
    check("flywheel_locked", 32'(locked), 32'd1);

    // Loss of lock then relock
    frame(1'b0, -1, 0, 1'b0, 0);
    frame(1'b0, -1, 0, 1'b0, 0);
    frame(1'b0, -1, 0, 1'b0, 0);
    t_ref = cyc;
    clear_counts();
    frame(1'b1, -1, 0, 1'b0, 0);
    check("loss_fall_time", 32'(lock_fall - t_ref), 32'd1);
    check("loss_no_grant", 32'(gnt_cyc), 32'd0);
    t_ref = cyc;
    frame(1'b1, -1, 0, 1'b0, 0);
    frame(1'b1, -1, 0, 1'b0, 0);
    frame(1'b1, -1, 0, 1'b0, 0);
    check("relock_latency", 32'(lock_rise - t_ref), 32'd1025);

    // Misaligned pulse in CHECK restarts the good count
    frame(1'b0, -1, 0, 1'b0, 0);
    frame(1'b0, -1, 0, 1'b0, 0);
    frame(1'b0, -1, 0, 1'b0, 0);
    frame(1'b1, -1, 0, 1'b0, 0);
    repeat (200) tick();
    pulse_now();
    t_ref = cyc;
    frame(1'b1, -1, 0, 1'b0, 0);
    check("misalign_not_locked", 32'(locked), 32'd0);
    frame(1'b1, -1, 0, 1'b0, 0);
    frame(1'b1, -1, 0, 1'b0, 0);
    check("misalign_lock_latency", 32'(lock_rise - t_ref), 32'd1025);

    // Mid-slot reconfiguration of slot 5 to owner 2
    clear_counts();
    frame(1'b1, 85, 5, 1'b1, 2);
    check("midslot_old_owner0", 32'(tx_cnt[0]), 32'd16);
    check("midslot_old_owner2", 32'(tx_cnt[2]), 32'd8);
    clear_counts();
    frame(1'b1, -1, 0, 1'b0, 0);
    check("midslot_new_owner0", 32'(tx_cnt[0]), 32'd8);
    check("midslot_new_owner2", 32'(rx_cnt[2]), 32'd16);
    // Write landing on slot 5's start edge: old owner still latched this frame
    clear_counts();
    frame(1'b1, 80, 5, 1'b1, 1);
    check("slotstart_old_owner2", 32'(tx_cnt[2]), 32'd16);
    check("slotstart_old_owner1", 32'(tx_cnt[1]), 32'd8);
    clear_counts();
    frame(1'b1, 200, 9, 1'b1, 3);
    check("slotstart_new_owner1", 32'(tx_cnt[1]), 32'd16);
    clear_counts();
    frame(1'b1, -1, 0, 1'b0, 0);
    check("owner3_no_grant", 32'(gnt_cyc), 32'd64);

    // Reset during slot 10 with tx_en[2] active
    for (int i = 0; i < 165; i++) tick();
    check("pre_reset_tx", 32'(tx_en), 32'b100);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_slot_bitn", 32'({slot, bitn}), 32'd0);
    check("midrst_flags", 32'({sof, locked}), 32'd0);
    check("midrst_strobes", 32'({grant, tx_en, rx_en}), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    pulse_now();
    frame(1'b1, -1, 0, 1'b0, 0);
    frame(1'b1, -1, 0, 1'b0, 0);
    clear_counts();
    frame(1'b1, -1, 0, 1'b0, 0);
    check("post_rst_locked", 32'(locked), 32'd1);
    check("post_rst_map_cleared", 32'(gnt_cyc), 32'd0);
    frame(1'b1, 10, 3, 1'b1, 1);
    clear_counts();
    frame(1'b1, -1, 0, 1'b0, 0);
    check("post_rst_rewrite_tx1", 32'(tx_cnt[1]), 32'd8);
    check("post_rst_rewrite_grant", 32'(gnt_cyc), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
